// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the parametrised AHB arbiter.
package ahb_arb_pkg;

    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned MAX_IW      = 4;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    // Index of the set bit in a one-hot vector (zero when empty).
    function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_MASTERS); i++) begin
            if (oh[i]) idx = idx | MAX_IW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational rotating-priority picker: first set request at or after
// start (wrapping), or lowest set request when rotation is disabled.
module ahb_arb_pick
    import ahb_arb_pkg::*;
#(
    parameter  int unsigned N  = 16,
    localparam int unsigned MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    input  logic          rr_en,
    output logic [N-1:0]  win_c,
    output logic          valid_c
);

    localparam int unsigned IW = MW + 1;

    logic [IW-1:0] idx;

    // Scan N candidates starting at the effective start index.
    always_comb begin
        win_c   = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = (rr_en ? {1'b0, start} : IW'(0)) + IW'(k);
            if (idx >= IW'(N)) idx = idx - IW'(N);
            if (!valid_c && req[idx[MW-1:0]]) begin
                win_c[idx[MW-1:0]] = 1'b1;
                valid_c            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: fixed-priority or round-robin grant, locked
// transfer holding, SPLIT masking with HSPLIT release, address handover.
// Optional assertions are compiled when AHB_ARB_SVA_EN is defined.
module ahb_arbiter_param
    import ahb_arb_pkg::*;
#(
    parameter  int unsigned N_MASTERS      = 16,
    parameter  int unsigned DEFAULT_MASTER = 0,
    parameter  int unsigned ROUND_ROBIN    = 1,
    localparam int unsigned MW             = $clog2(N_MASTERS)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [N_MASTERS-1:0] HBUSREQx,
    input  logic [N_MASTERS-1:0] HLOCKx,
    input  logic [N_MASTERS-1:0] HSPLIT,
    input  logic                 HREADY,
    input  logic [1:0]           HRESP,
    output logic [N_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]        HMASTER,
    output logic                 HMASTLOCK
);

    localparam logic [N_MASTERS-1:0] DEF_OH  = N_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]        DEF_IDX = MW'(DEFAULT_MASTER);

    logic [MW-1:0]        rr_ptr;
    logic [MW-1:0]        start_c;
    logic [MW-1:0]        g_idx_c;
    logic [MW-1:0]        win_idx_c;
    logic [N_MASTERS-1:0] split_mask;
    logic [N_MASTERS-1:0] elig_c;
    logic [N_MASTERS-1:0] win_c;
    logic [N_MASTERS-1:0] split_set_c;
    logic                 win_valid_c;
    logic                 arb_point_c;

    assign g_idx_c     = MW'(onehot_to_idx(MAX_MASTERS'(HGRANTx)));
    assign win_idx_c   = MW'(onehot_to_idx(MAX_MASTERS'(win_c)));
    assign elig_c      = HBUSREQx & ~split_mask;
    assign start_c     = (rr_ptr == MW'(N_MASTERS - 1)) ? '0 : rr_ptr + MW'(1);
    assign arb_point_c = HREADY && !(HLOCKx[g_idx_c] && HBUSREQx[g_idx_c]);
    assign split_set_c = (hresp_t'(HRESP) == SPLIT && !HREADY) ? (N_MASTERS'(1) << HMASTER) : '0;

    ahb_arb_pick #(.N(N_MASTERS)) u_pick (
        .req     (elig_c),
        .start   (start_c),
        .rr_en   (ROUND_ROBIN != 0),
        .win_c   (win_c),
        .valid_c (win_valid_c)
    );

    // Grant and rotation pointer update at arbitration points only.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANTx <= DEF_OH;
            rr_ptr  <= DEF_IDX;
        end else if (arb_point_c) begin
            if (win_valid_c) begin
                HGRANTx <= win_c;
                if (ROUND_ROBIN != 0) rr_ptr <= win_idx_c;
            end else begin
                HGRANTx <= DEF_OH;
            end
        end
    end

    // Address-phase ownership follows the grant whenever the bus is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            HMASTER   <= g_idx_c;
            HMASTLOCK <= HLOCKx[g_idx_c];
        end
    end

    // Split mask: a new SPLIT on the owner beats a same-edge release.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            split_mask <= '0;
        end else begin
            split_mask <= (split_mask & ~HSPLIT) | split_set_c;
        end
    end

`ifdef AHB_ARB_SVA_EN
    logic [4:0] starve_cnt [N_MASTERS];

    // Arbitration points seen by each eligible, ungranted requester.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(N_MASTERS); i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                if (!HBUSREQx[i] || split_mask[i] || HGRANTx[i]) starve_cnt[i] <= '0;
                else if (arb_point_c && starve_cnt[i] != '1) starve_cnt[i] <= starve_cnt[i] + 5'd1;
            end
        end
    end

    a_req_known: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !$isunknown(HBUSREQx))
        else $error("%0t %m: HBUSREQx has X/Z", $time);

    a_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot(HGRANTx))
        else $error("%0t %m: HGRANTx not one-hot", $time);

    a_lock_hold: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (HLOCKx[g_idx_c] && HBUSREQx[g_idx_c]) |=> $stable(HGRANTx))
        else $error("%0t %m: grant moved while locked owner requests", $time);

    a_stall_hold: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !HREADY |=> ($stable(HMASTER) && $stable(HMASTLOCK)))
        else $error("%0t %m: HMASTER changed during wait state", $time);

    a_masked_grant: assert property (@(posedge HCLK) disable iff (!HRESETn)
        1'b1 |=> ((HGRANTx & ~$past(HGRANTx) & $past(split_mask) & ~DEF_OH) == '0))
        else $error("%0t %m: masked master newly granted", $time);

    if (ROUND_ROBIN != 0) begin : g_starve
        for (genvar i = 0; i < int'(N_MASTERS); i++) begin : g_m
            a_starve: assert property (@(posedge HCLK) disable iff (!HRESETn)
                starve_cnt[i] <= 5'(N_MASTERS))
                else $error("%0t %m: master %0d starved", $time, i);
        end
    end
`endif

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Self-checking bench: round-robin (default 0) and fixed-priority (default 5)
// arbiters on shared inputs, checked against a behavioural model.
module tb_ahb_arbiter_param;

    logic        HCLK;
    logic        rst_n;
    logic [15:0] busreq, lockx, hsplit;
    logic        hready;
    logic [1:0]  hresp;

    logic [15:0] rr_grant, fp_grant;
    logic [3:0]  rr_master, fp_master;
    logic        rr_lock, fp_lock;

    int checks;
    int failures;

    // Model state per instance: 0 = round-robin, 1 = fixed priority.
    logic [3:0]  m_g    [2];
    logic [3:0]  m_hm   [2];
    logic        m_hl   [2];
    logic [15:0] m_mask [2];
    logic [3:0]  m_ptr  [2];
    logic [3:0]  m_def  [2];
    bit          m_rr   [2];

    ahb_arbiter_param #(.N_MASTERS(16), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(rst_n), .HBUSREQx(busreq), .HLOCKx(lockx),
        .HSPLIT(hsplit), .HREADY(hready), .HRESP(hresp),
        .HGRANTx(rr_grant), .HMASTER(rr_master), .HMASTLOCK(rr_lock)
    );

    ahb_arbiter_param #(.N_MASTERS(16), .DEFAULT_MASTER(5), .ROUND_ROBIN(0)) dut_fp (
        .HCLK(HCLK), .HRESETn(rst_n), .HBUSREQx(busreq), .HLOCKx(lockx),
        .HSPLIT(hsplit), .HREADY(hready), .HRESP(hresp),
        .HGRANTx(fp_grant), .HMASTER(fp_master), .HMASTLOCK(fp_lock)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_def[0] = 4'd0;  m_rr[0] = 1'b1;
        m_def[1] = 4'd5;  m_rr[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_g[u]    = m_def[u];
            m_hm[u]   = m_def[u];
            m_hl[u]   = 1'b0;
            m_mask[u] = '0;
            m_ptr[u]  = m_def[u];
        end
    endtask

    // One rising edge of the arbiter rules, from the inputs seen at the edge.
    task automatic model_step(input int u);
        logic [15:0] elig;
        logic [15:0] setv;
        logic [3:0]  g, ng, np, c;
        bit          arb;
        g    = m_g[u];
        ng   = g;
        np   = m_ptr[u];
        elig = busreq & ~m_mask[u];
        arb  = hready && !(lockx[g] && busreq[g]);
        if (arb) begin
            if (elig == 16'h0) begin
                ng = m_def[u];
            end else if (m_rr[u]) begin
                for (int k = 1; k <= 16; k++) begin
                    c = m_ptr[u] + 4'(k);
                    if (elig[c]) begin
                        ng = c;
                        np = c;
                        break;
                    end
                end
            end else begin
                for (int k = 15; k >= 0; k--) begin
                    if (elig[k]) ng = 4'(k);
                end
            end
        end
        setv = (hresp == 2'b11 && !hready) ? (16'h1 << m_hm[u]) : 16'h0;
        m_mask[u] = (m_mask[u] & ~hsplit) | setv;
        if (hready) begin
            m_hm[u] = g;
            m_hl[u] = lockx[g];
        end
        m_g[u]   = ng;
        m_ptr[u] = np;
    endtask

    task automatic cmp_model();
        chk("rr_grant",  32'(rr_grant),  32'(16'h1 << m_g[0]));
        chk("rr_master", 32'(rr_master), 32'(m_hm[0]));
        chk("rr_lock",   32'(rr_lock),   32'(m_hl[0]));
        chk("fp_grant",  32'(fp_grant),  32'(16'h1 << m_g[1]));
        chk("fp_master", 32'(fp_master), 32'(m_hm[1]));
        chk("fp_lock",   32'(fp_lock),   32'(m_hl[1]));
    endtask

    // Advance one clock, update the model, then compare just after the edge.
    task automatic step();
        @(posedge HCLK);
        model_step(0);
        model_step(1);
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic [15:0] req, input logic [15:0] lck,
                         input logic rdy, input logic [1:0] rsp, input logic [15:0] spl);
        busreq = req;
        lockx  = lck;
        hready = rdy;
        hresp  = rsp;
        hsplit = spl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        drive(16'h0, 16'h0, 1'b1, 2'b00, 16'h0);

        // Reset values
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_rr_grant",  32'(rr_grant),  32'h0001);
        chk("rst_rr_master", 32'(rr_master), 32'h0);
        chk("rst_rr_lock",   32'(rr_lock),   32'h0);
        chk("rst_fp_grant",  32'(fp_grant),  32'h0020);
        chk("rst_fp_master", 32'(fp_master), 32'h5);
        rst_n = 1'b1;

        // Round-robin rotation 1,2,3,1 with HMASTER one cycle behind
        drive(16'h000E, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("rr_seq0_g", 32'(rr_grant), 32'h0002); chk("rr_seq0_m", 32'(rr_master), 32'd0);
        chk("fp_low_g", 32'(fp_grant), 32'h0002);
        step(); chk("rr_seq1_g", 32'(rr_grant), 32'h0004); chk("rr_seq1_m", 32'(rr_master), 32'd1);
        step(); chk("rr_seq2_g", 32'(rr_grant), 32'h0008); chk("rr_seq2_m", 32'(rr_master), 32'd2);
        step(); chk("rr_seq3_g", 32'(rr_grant), 32'h0002); chk("rr_seq3_m", 32'(rr_master), 32'd3);

        // Fixed priority: master 2 always beats master 3
        drive(16'h000C, 16'h0, 1'b1, 2'b00, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fp_prio_g", 32'(fp_grant), 32'h0004);
        end

        // Lock hold on master 1, then release hands over to master 2
        drive(16'h0002, 16'h0002, 1'b1, 2'b00, 16'h0);
        step(); chk("lock_take_g", 32'(rr_grant), 32'h0002);
        drive(16'h0006, 16'h0002, 1'b1, 2'b00, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_hold_g",  32'(rr_grant), 32'h0002);
            chk("lock_mastlk",  32'(rr_lock),  32'h1);
        end
        drive(16'h0006, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("lock_drop_g", 32'(rr_grant), 32'h0004);

        // Split masking on master 2 and HSPLIT release
        drive(16'h0004, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("split_own_m", 32'(rr_master), 32'd2);
        drive(16'h0004, 16'h0, 1'b0, 2'b11, 16'h0);
        step();
        drive(16'h000C, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("split_move_g", 32'(rr_grant), 32'h0008);
        drive(16'h0004, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("split_def_g", 32'(rr_grant), 32'h0001);
        drive(16'h0004, 16'h0, 1'b1, 2'b00, 16'h0004);
        step(); chk("split_rel_edge_g", 32'(rr_grant), 32'h0001);
        drive(16'h0004, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("split_back_g", 32'(rr_grant), 32'h0004);
        step(); chk("split_back_m", 32'(rr_master), 32'd2);
        drive(16'h0004, 16'h0, 1'b0, 2'b11, 16'h0004);
        step();
        drive(16'h0004, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("split_setwins_g", 32'(rr_grant), 32'h0001);

        // Wait states freeze grant and handover
        for (int i = 0; i < 4; i++) begin
            drive(16'($urandom), 16'($urandom), 1'b0, 2'b00, 16'h0);
            step();
            chk("stall_g",  32'(rr_grant),  32'h0001);
            chk("stall_m",  32'(rr_master), 32'd2);
            chk("stall_lk", 32'(rr_lock),   32'h0);
        end
        drive(16'h0008, 16'h0, 1'b1, 2'b00, 16'h0);
        step(); chk("stall_end_g", 32'(rr_grant), 32'h0008); chk("stall_end_m", 32'(rr_master), 32'd0);

        // Randomized traffic against the model, with an async reset midway
        for (int i = 0; i < 600; i++) begin
            busreq = 16'($urandom);
            lockx  = busreq & 16'($urandom) & 16'($urandom);
            hready = ($urandom_range(0, 3) != 0);
            hresp  = 2'($urandom);
            hsplit = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            step();
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_rr_g", 32'(rr_grant),  32'h0001);
                chk("midrst_rr_m", 32'(rr_master), 32'h0);
                chk("midrst_rr_l", 32'(rr_lock),   32'h0);
                chk("midrst_fp_g", 32'(fp_grant),  32'h0020);
                chk("midrst_fp_m", 32'(fp_master), 32'h5);
                model_reset();
                @(negedge HCLK);
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_param.md
Name: ahb_arbiter_param

Overview:
- Parametrised successor to the 16-master AHB arbiter.
- Master count, default master and arbitration mode are parameters; fixed-priority or round-robin selectable.
- Adds SPLIT-response masking with HSPLIT release and locked-transfer grant holding.
- Sits between all bus masters and the address/control mux. HMASTER drives the mux select; HMASTLOCK goes to slaves.

Parameters:
- N_MASTERS, 16, number of masters (2..16).
- DEFAULT_MASTER, 0, index granted when no eligible request exists.
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- MW, $clog2(N_MASTERS), HMASTER width (localparam).

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  reset, asynchronous and active-low.
- HBUSREQx  in  N_MASTERS  per-master bus request.
- HLOCKx  in  N_MASTERS  per-master lock request.
- HSPLIT  in  N_MASTERS  OR of slave split-release vectors; bit i unmasks master i.
- HREADY  in  1  transfer complete.
- HRESP  in  2  slave response (OKAY/ERROR/RETRY/SPLIT).
- HGRANTx  out  N_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  index of master owning the address phase, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Reset (async, HRESETn=0):
  - HGRANTx = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - Split mask = 0, RR pointer = DEFAULT_MASTER.
- Reset mid-operation: all state returns to reset values immediately. There is no resumption of pending grants.
- HGRANTx is exactly one-hot in every cycle, never zero.
- Eligible set = HBUSREQx & ~split_mask.
- Arbitration point: rising edge with HREADY=1 AND NOT (HLOCKx[g] & HBUSREQx[g]), where g is the currently granted index.
  - At an arbitration point, the next grant is computed from the eligible set and HGRANTx updates after the edge (1-cycle latency).
  - Elsewhere, HGRANTx holds.
- Fixed mode: lowest-index eligible master wins.
- Round-robin mode:
  - Search starts at pointer+1 and wraps at N_MASTERS-1 -> 0.
  - Pointer updates to the winner only when the winner was eligible.
- Empty eligible set: grant DEFAULT_MASTER. This applies even if DEFAULT_MASTER is masked; it must issue IDLE. The pointer is unchanged.
- Lock: while the granted master holds HLOCKx and HBUSREQx, the grant is held regardless of other requests. A lock-only request (HLOCKx without HBUSREQx) is ignored.
- Address-phase handover, on each rising edge with HREADY=1:
  - HMASTER <= index(HGRANTx).
  - HMASTLOCK <= HLOCKx[index(HGRANTx)].
  - With HREADY=0, both hold.
- Split masking:
  - Set: on an edge where HRESP==SPLIT and HREADY==0 (first split cycle), set split_mask[HMASTER].
  - Clear: split_mask[i] clears on any edge with HSPLIT[i]=1.
  - Same-edge set and clear for the same bit: set wins.
  - A master that becomes masked while granted loses the grant at the next arbitration point.
- HSPLIT bits at index >= N_MASTERS are not present. HBUSREQx X-free inputs are required by assertion only.

Optional Feature:
- Macro: AHB_ARB_SVA_EN.
- When defined, the block compiles concurrent assertions:
  - onehot HGRANTx;
  - grant stable while the locked owner requests;
  - HMASTER stable while HREADY=0;
  - masked master never newly granted;
  - a master requesting continuously is granted within N_MASTERS arbitration points (RR mode only).
- Each assertion reports $error with time and hierarchy.
- When undefined: no assertion code, identical RTL behaviour.

Decomposition:
- Package ahb_arb_pkg holds:
  - hresp_t enum (OKAY=2'b00, ERROR=2'b01, RETRY=2'b10, SPLIT=2'b11);
  - MAX_MASTERS=16;
  - function onehot_to_idx.
- Sub-module ahb_arb_pick: combinational rotating priority picker.
  - Inputs: req vector, start index, rr_en.
  - Outputs: winner one-hot and a valid flag.
- The top level holds the registers, lock/split logic and handover.

Test Plan:
- Reset: HRESETn low with DEFAULT_MASTER=0 -> HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0; assert again mid-burst -> same values asynchronously.
- Round-robin: HBUSREQx=16'h000E held, HREADY=1 -> grants cycle 1,2,3,1 on consecutive edges; HMASTER lags grant by one cycle.
- Fixed priority: ROUND_ROBIN=0, HBUSREQx=16'h000C -> master 2 granted continuously, master 3 never granted.
- Lock hold: master 1 granted with HLOCKx[1]=1, HBUSREQx=16'h0006 -> grant stays at 1 for 5 cycles; HMASTLOCK=1 from the next HREADY edge; lock dropped -> master 2 granted next edge.
- Split: master 2 owning with HRESP=SPLIT, HREADY=0 -> master 2 masked, grant moves to master 3 (or default); HSPLIT[2] pulse -> master 2 eligible again; same-edge set/clear -> remains masked.
- Stall: HREADY=0 for 4 cycles with changing requests -> HGRANTx, HMASTER and HMASTLOCK unchanged; update on the first HREADY=1 edge.
